hyperbus_udma_tx_fetch: RTL and testbench
=========================================

HYPERBUS_UDMA_TX_FETCH -- requirements
Module: hyperbus_udma_tx_fetch

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DataWidth, default 32, the uDMA TX data and output word width.
REQ-003 SHALL have parameter BufferDepth, default 4, the number of buffer slots; power of two, at least 2.
REQ-004 SHALL have parameter TransSize, default 16, the width of the byte-size field.
REQ-005 SHALL have these ports, clock and reset first:
- clk_sys_i  in  1  system clock
- rst_sys_i  in  1  async active-high reset
- clr_i  in  1  synchronous abort/flush
- start_i  in  1  start-transfer pulse
- size_i  in  TransSize  transfer length, bytes
- datasize_i  in  2  beat size: 0=1 B, 1=2 B, 2=4 B, 3=reserved (treated as 4 B)
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle end-of-transfer pulse
- data_tx_req_o  out  1  uDMA read request
- data_tx_gnt_i  in  1  uDMA grant
- data_tx_i  in  DataWidth  uDMA read data
- data_tx_valid_i  in  1  uDMA data valid
- data_tx_ready_o  out  1  uDMA data ready
- data_o  out  DataWidth  stream data toward the TX CDC FIFO source
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready

Function
REQ-006 SHALL implement three states, IDLE, FETCH and DRAIN; the state SHALL be IDLE after reset.
REQ-007 In IDLE, start_i SHALL latch beats = ceil(size_i / bytes-per-beat) and datasize_i, then enter FETCH with busy_o=1 on the next cycle.
REQ-008 start_i SHALL be ignored while busy_o=1.
REQ-009 If size_i=0 at start, the block SHALL issue no request and SHALL pulse done_o on the next cycle while remaining in IDLE.
REQ-010 Credit SHALL be BufferDepth minus (occupancy plus outstanding); outstanding = granted requests whose data has not yet returned.
REQ-011 data_tx_req_o SHALL be 1 only when the state is FETCH, req_left > 0 and credit > 0.
REQ-012 Each cycle with req&gnt SHALL decrement req_left and increment outstanding.
REQ-013 When req_left reaches 0, the state SHALL move to DRAIN.
REQ-014 data_tx_ready_o SHALL be constant 1; credit guarantees space for every response.
REQ-015 Each data_tx_valid_i SHALL decrement outstanding and write data_tx_i into the buffer, except while dropping (REQ-021).
REQ-016 The buffer SHALL be in-order FIFO; valid_o = not empty; data_o = head word; pop on valid_o&ready_i.
REQ-017 Push and pop in the same cycle SHALL both occur, including when the buffer is full and when it is empty (write-through is not required; the word appears on data_o one cycle later).
REQ-018 A grant and a data return in the same cycle SHALL leave outstanding unchanged.
REQ-019 In DRAIN, when outstanding=0, the buffer is empty and no pop is pending, done_o SHALL pulse for one cycle, the state SHALL return to IDLE and busy_o SHALL fall in the same cycle as the pulse.
REQ-020 Latency from data_tx_valid_i to valid_o SHALL be 1 cycle.
REQ-021 clr_i SHALL:
- force IDLE, flush the buffer and zero req_left;
- not pulse done_o;
- keep outstanding counting, and drop returning data until outstanding=0;
- make start_i wait in IDLE while dropping (start ignored, busy_o=0).
REQ-022 Counters SHALL be wide enough that they never wrap: req_left has TransSize bits; outstanding has clog2(BufferDepth)+1 bits.
REQ-023 A data_tx_valid_i with outstanding=0 SHALL be ignored.

Reset
REQ-024 Reset SHALL asynchronously force the following:
- state IDLE
- buffer empty
- req_left=0 and outstanding=0
- busy_o=0, done_o=0, data_tx_req_o=0 and valid_o=0
- data_o=0
- data_tx_ready_o=1
REQ-025 Reset asserted mid-transfer SHALL discard everything, with no done_o pulse; responses arriving after reset are ignored per REQ-023.

Structure
REQ-026 Package hyperbus_udma_pkg SHALL hold the datasize encoding (enum) and the bytes-per-beat function.
REQ-027 The buffer SHALL be one sub-module, hyperbus_udma_tx_buf (parametric FIFO with full/empty/usage outputs); control and credit SHALL stay in the top.

Verification
REQ-028 Start size=16, datasize=2, with gnt=1 and data returned 1 cycle after each grant, and ready_i=1 -> exactly 4 requests; 4 words out in order; done_o pulses once.
REQ-029 Start size=5, datasize=1 -> 3 requests (ceil); done_o pulses after the third word is popped.
REQ-030 BufferDepth=4, ready_i=0, size=64, datasize=2 -> request count reaches 4, then data_tx_req_o stays 0; releasing ready_i resumes requests; 16 words total, with no overflow.
REQ-031 Start with size=0 -> no data_tx_req_o; done_o pulses on the next cycle; busy_o stays 0.
REQ-032 Assert clr_i with 2 requests outstanding -> the 2 late responses are dropped (valid_o stays 0), there is no done_o pulse, and start_i is ignored until both responses have returned.
REQ-033 Assert rst_sys_i mid-FETCH -> all outputs reach their reset values asynchronously in the same cycle, with no done_o pulse.

Source files
------------

// File: rtl/hyperbus_udma_pkg.sv
// Shared definitions for the HyperBus uDMA TX fetch path: beat-size encoding
// and helpers that turn a beat size into byte counts and shift amounts.
package hyperbus_udma_pkg;

    typedef enum logic [1:0] {
        DS_1B   = 2'd0,
        DS_2B   = 2'd1,
        DS_4B   = 2'd2,
        DS_RSVD = 2'd3
    } datasize_e;

    // The reserved encoding behaves exactly like a 4-byte beat.
    function automatic logic [2:0] bytes_per_beat(input datasize_e ds);
        case (ds)
            DS_1B:   return 3'd1;
            DS_2B:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] beat_shift(input datasize_e ds);
        case (ds)
            DS_1B:   return 2'd0;
            DS_2B:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/hyperbus_udma_tx_buf.sv
// In-order word buffer between the uDMA response port and the TX stream.
// Push and pop may coincide; flush empties it in one cycle.
module hyperbus_udma_tx_buf #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DataWidth-1:0]   i_data,
    input  logic                   i_pop,
    output logic [DataWidth-1:0]   o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(Depth):0] o_usage
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] FullC = (AW+1)'(Depth);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_usage;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_full    = (r_usage == FullC);
    assign o_empty   = (r_usage == '0);
    assign o_usage   = r_usage;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;
    assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

    // Storage needs no reset: the top masks the head word while empty.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_usage <= r_usage + (AW+1)'(1);
                2'b01:   r_usage <= r_usage - (AW+1)'(1);
                default: r_usage <= r_usage;
            endcase
        end
    end

endmodule

// File: rtl/hyperbus_udma_tx_fetch.sv
// Fetches a transfer's worth of words from the uDMA TX port under a credit
// scheme sized to the local buffer, and streams them out in order.
module hyperbus_udma_tx_fetch
    import hyperbus_udma_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int BufferDepth = 4,
    parameter int TransSize   = 16
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 clr_i,
    input  logic                 start_i,
    input  logic [TransSize-1:0] size_i,
    input  logic [1:0]           datasize_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 data_tx_req_o,
    input  logic                 data_tx_gnt_i,
    input  logic [DataWidth-1:0] data_tx_i,
    input  logic                 data_tx_valid_i,
    output logic                 data_tx_ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CntW = $clog2(BufferDepth) + 1;
    localparam logic [CntW:0] DepthC = (CntW+1)'(BufferDepth);

    logic [1:0]           r_state;
    logic [TransSize-1:0] r_req_left;
    logic [CntW-1:0]      r_outstanding;
    logic                 r_drop;
    logic                 r_done;

    datasize_e            w_ds;
    logic [1:0]           w_shift;
    logic [TransSize-1:0] w_mask;
    logic [TransSize-1:0] w_beats;
    logic [CntW-1:0]      w_usage;
    logic [CntW-1:0]      w_out_next;
    logic [CntW:0]        w_committed;
    logic                 w_credit_ok;
    logic                 w_grant;
    logic                 w_rsp;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DataWidth-1:0] w_head;

    // Beat count is ceil(size / bytes_per_beat) without risking overflow of size_i.
    assign w_ds    = datasize_e'(datasize_i);
    assign w_shift = beat_shift(w_ds);
    assign w_mask  = TransSize'(bytes_per_beat(w_ds)) - TransSize'(1);
    assign w_beats = (size_i >> w_shift) + TransSize'(|(size_i & w_mask));

    // Every granted request owns a buffer slot until its word is popped.
    assign w_committed = {1'b0, w_usage} + {1'b0, r_outstanding};
    assign w_credit_ok = !w_full && (w_committed < DepthC);

    assign data_tx_req_o   = (r_state == ST_FETCH) && (r_req_left != '0) && w_credit_ok;
    assign data_tx_ready_o = 1'b1;
    assign w_grant         = data_tx_req_o && data_tx_gnt_i;
    assign w_rsp           = data_tx_valid_i && (r_outstanding != '0);
    assign w_push          = w_rsp && !r_drop && !clr_i;

    assign valid_o = !w_empty;
    assign data_o  = w_empty ? '0 : w_head;
    assign w_pop   = valid_o && ready_i;
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = r_done;

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_grant, w_rsp})
            2'b10:   w_out_next = r_outstanding + CntW'(1);
            2'b01:   w_out_next = r_outstanding - CntW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_state       <= ST_IDLE;
            r_req_left    <= '0;
            r_outstanding <= '0;
            r_drop        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            // After an abort, late responses are discarded until none remain in flight.
            r_drop        <= (clr_i || r_drop) && (w_out_next != '0);
            if (clr_i) begin
                r_state    <= ST_IDLE;
                r_req_left <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && !r_drop) begin
                            if (size_i == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state    <= ST_FETCH;
                                r_req_left <= w_beats;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (w_grant) begin
                            r_req_left <= r_req_left - TransSize'(1);
                        end
                        if ((r_req_left == '0) || (w_grant && (r_req_left == TransSize'(1)))) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((r_outstanding == '0) && w_empty) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    hyperbus_udma_tx_buf #(
        .DataWidth (DataWidth),
        .Depth     (BufferDepth)
    ) u_buf (
        .i_clk   (clk_sys_i),
        .i_rst   (rst_sys_i),
        .i_flush (clr_i),
        .i_push  (w_push),
        .i_data  (data_tx_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_usage (w_usage)
    );

endmodule

// File: tb/tb_hyperbus_udma_tx_fetch.sv
// Bench for hyperbus_udma_tx_fetch: table-driven and randomized transfers
// against a transfer-level model, plus abort and reset sequences.
module tb_hyperbus_udma_tx_fetch;

    localparam int DW = 32;
    localparam int BD = 4;
    localparam int TS = 16;

    logic          clk_sys_i = 1'b0;
    logic          rst_sys_i;
    logic          clr_i;
    logic          start_i;
    logic [TS-1:0] size_i;
    logic [1:0]    datasize_i;
    logic          busy_o;
    logic          done_o;
    logic          data_tx_req_o;
    logic          data_tx_gnt_i;
    logic [DW-1:0] data_tx_i;
    logic          data_tx_valid_i;
    logic          data_tx_ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        int size;
        int ds;
        int gnt_pct;
        int rdy_pct;
        int lat_max;
        int hold;
        int exp_beats;
    } vec_t;

    vec_t vecs[9];

    hyperbus_udma_tx_fetch #(
        .DataWidth   (DW),
        .BufferDepth (BD),
        .TransSize   (TS)
    ) dut (
        .clk_sys_i       (clk_sys_i),
        .rst_sys_i       (rst_sys_i),
        .clr_i           (clr_i),
        .start_i         (start_i),
        .size_i          (size_i),
        .datasize_i      (datasize_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .data_tx_req_o   (data_tx_req_o),
        .data_tx_gnt_i   (data_tx_gnt_i),
        .data_tx_i       (data_tx_i),
        .data_tx_valid_i (data_tx_valid_i),
        .data_tx_ready_o (data_tx_ready_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_beats(input int size, input int ds);
        int bpb;
        bpb = (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
        return (size + bpb - 1) / bpb;
    endfunction

    task automatic step();
        @(posedge clk_sys_i);
        #1;
    endtask

    // One complete transfer; called at 1 time unit after a rising edge with the DUT idle.
    task automatic run_xfer(input string nm, input int size, input int ds, input int gnt_pct,
                            input int rdy_pct, input int lat_max, input int hold, input int exp_beats);
        int reqs = 0;
        int words = 0;
        int dones = 0;
        int done_cyc = -1;
        int max_inflight = 0;
        int post = -1;
        int last_due = -1;
        int cyc = 0;
        bit busy_seen = 0;
        bit finished = 0;
        int pend_due[$];
        logic [DW-1:0] pend_dat[$];
        logic [DW-1:0] exp_w;
        int due;

        exp_q.delete();
        start_i    = 1'b1;
        size_i     = TS'(size);
        datasize_i = 2'(ds);
        step();
        start_i = 1'b0;

        while (cyc < 3000) begin
            if (hold > 0 && cyc == hold) begin
                check({nm, ".reqs_at_hold"}, reqs, (exp_beats < BD) ? exp_beats : BD);
                check({nm, ".req_stalled"}, data_tx_req_o, 0);
            end
            if (busy_o) busy_seen = 1;
            if (done_o) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc;
                    check({nm, ".busy_at_done"}, busy_o, 0);
                    check({nm, ".words_at_done"}, words, exp_beats);
                    post = 3;
                end
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                data_tx_i       = pend_dat.pop_front();
                data_tx_valid_i = 1'b1;
                exp_q.push_back(data_tx_i);
            end else begin
                data_tx_valid_i = 1'b0;
                data_tx_i       = $urandom;
            end
            data_tx_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
            if (data_tx_req_o && data_tx_gnt_i) begin
                reqs++;
                due = cyc + $urandom_range(1, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_due.push_back(due);
                pend_dat.push_back($urandom);
            end
            ready_i = (cyc >= hold) && ($urandom_range(1, 100) <= rdy_pct);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check({nm, ".unexpected_word"}, data_o, 'x);
                end else begin
                    exp_w = exp_q.pop_front();
                    check($sformatf("%s.word%0d", nm, words), data_o, exp_w);
                end
                words++;
            end
            if (reqs - words > max_inflight) max_inflight = reqs - words;
            if (post > 0) begin
                post--;
                if (post == 0) begin
                    finished = 1;
                end
            end
            step();
            cyc++;
            if (finished) break;
        end

        data_tx_valid_i = 1'b0;
        data_tx_gnt_i   = 1'b0;
        ready_i         = 1'b0;
        check({nm, ".completed"}, finished, 1);
        check({nm, ".requests"}, reqs, exp_beats);
        check({nm, ".words"}, words, exp_beats);
        check({nm, ".done_pulses"}, dones, 1);
        check({nm, ".leftover"}, exp_q.size(), 0);
        check({nm, ".no_overflow"}, max_inflight <= BD, 1);
        if (exp_beats == 0) begin
            check({nm, ".zero_busy"}, busy_seen, 0);
            check({nm, ".zero_done_cycle"}, done_cyc, 0);
        end
    endtask

    initial begin
        rst_sys_i       = 1'b1;
        clr_i           = 1'b0;
        start_i         = 1'b0;
        size_i          = '0;
        datasize_i      = 2'd0;
        data_tx_gnt_i   = 1'b0;
        data_tx_i       = '0;
        data_tx_valid_i = 1'b0;
        ready_i         = 1'b0;

        //            size ds gnt rdy lat hold beats
        vecs[0] = '{  16,  2, 100, 100, 1,  0,  4};
        vecs[1] = '{   5,  1, 100, 100, 1,  0,  3};
        vecs[2] = '{  64,  2, 100, 100, 1, 20, 16};
        vecs[3] = '{   0,  2, 100, 100, 1,  0,  0};
        vecs[4] = '{   7,  0, 100, 100, 1,  0,  7};
        vecs[5] = '{   7,  3,  60,  70, 3,  0,  2};
        vecs[6] = '{   1,  2, 100, 100, 1,  0,  1};
        vecs[7] = '{   3,  2, 100,  50, 2,  0,  1};
        vecs[8] = '{   9,  1,  50, 100, 3,  0,  5};

        repeat (3) @(posedge clk_sys_i);
        #1;
        check("reset.busy", busy_o, 0);
        check("reset.done", done_o, 0);
        check("reset.req", data_tx_req_o, 0);
        check("reset.valid", valid_o, 0);
        check("reset.data", data_o, 0);
        check("reset.tx_ready", data_tx_ready_o, 1);
        rst_sys_i = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].size, vecs[i].ds, vecs[i].gnt_pct,
                     vecs[i].rdy_pct, vecs[i].lat_max, vecs[i].hold, vecs[i].exp_beats);
        end

        // Abort with two requests in flight; their data must vanish.
        start_i    = 1'b1;
        size_i     = TS'(64);
        datasize_i = 2'd2;
        step();
        start_i = 1'b0;
        check("clr.req0", data_tx_req_o, 1);
        data_tx_gnt_i = 1'b1;
        step();
        check("clr.req1", data_tx_req_o, 1);
        step();
        data_tx_gnt_i = 1'b0;
        clr_i         = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr.req_after", data_tx_req_o, 0);
        for (int k = 0; k < 3; k++) begin
            start_i         = 1'b1;
            size_i          = TS'(16);
            datasize_i      = 2'd2;
            data_tx_valid_i = (k == 1 || k == 2);
            data_tx_i       = $urandom;
            step();
            check($sformatf("clr.busy%0d", k), busy_o, 0);
            check($sformatf("clr.valid%0d", k), valid_o, 0);
            check($sformatf("clr.done%0d", k), done_o, 0);
        end
        start_i         = 1'b0;
        data_tx_valid_i = 1'b0;
        step();
        check("clr.valid_late", valid_o, 0);
        check("clr.done_late", done_o, 0);
        run_xfer("after_clr", 16, 2, 100, 100, 1, 0, 4);

        for (int i = 0; i < 15; i++) begin
            int sz;
            int ds;
            sz = $urandom_range(0, 40);
            ds = $urandom_range(0, 3);
            run_xfer($sformatf("rnd%0d", i), sz, ds, $urandom_range(30, 100),
                     $urandom_range(30, 100), $urandom_range(1, 3), 0, model_beats(sz, ds));
        end

        // Reset in the middle of a fetch, with words sitting in the buffer.
        start_i    = 1'b1;
        size_i     = TS'(64);
        datasize_i = 2'd2;
        step();
        start_i       = 1'b0;
        data_tx_gnt_i = 1'b1;
        ready_i       = 1'b0;
        step();
        data_tx_valid_i = 1'b1;
        data_tx_i       = 32'hA5A5_0001;
        step();
        data_tx_i = 32'hA5A5_0002;
        step();
        check("rst.pre_busy", busy_o, 1);
        check("rst.pre_valid", valid_o, 1);
        #2;
        rst_sys_i = 1'b1;
        #1;
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        check("rst.req", data_tx_req_o, 0);
        check("rst.valid", valid_o, 0);
        check("rst.data", data_o, 0);
        check("rst.tx_ready", data_tx_ready_o, 1);
        data_tx_valid_i = 1'b0;
        data_tx_gnt_i   = 1'b0;
        step();
        rst_sys_i       = 1'b0;
        data_tx_valid_i = 1'b1;
        data_tx_i       = 32'hDEAD_BEEF;
        step();
        data_tx_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst.stray_valid%0d", k), valid_o, 0);
            check($sformatf("rst.no_done%0d", k), done_o, 0);
            check($sformatf("rst.idle%0d", k), busy_o, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
